// File: rtl/dwrr_pkt_sched.sv
// Deficit-weighted round-robin scheduler: shares one beat-per-cycle link among
// NUM_REQS packet queues using per-queue quanta and deficit counters.
module dwrr_pkt_sched #(
  parameter int NUM_REQS = 4,
  parameter int QWID     = 8,
  parameter int LWID     = 4,
  parameter int CNTWID   = $clog2(NUM_REQS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     blk,
  input  logic [NUM_REQS-1:0]      reqs,
  input  logic [NUM_REQS*LWID-1:0] req_lens,
  input  logic [NUM_REQS*QWID-1:0] input_quantums,
  output logic [NUM_REQS-1:0]      gnt,
  output logic                     xfer,
  output logic                     sop,
  output logic                     eop,
  output logic [CNTWID-1:0]        cur_idx
);

  // state | meaning
  // SCAN  | one credit / check / skip decision for queue ptr per cycle
  // SEND  | grant held on queue ptr until the last beat of its packet moves
  typedef enum logic {SCAN, SEND} state_t;

  state_t            state, state_nxt;
  logic [CNTWID-1:0] ptr, ptr_nxt;
  logic              visit, visit_nxt;
  logic [LWID-1:0]   beat_cnt, beat_nxt;
  logic [LWID-1:0]   len_q, len_nxt;
  logic [QWID-1:0]   def_cnt [NUM_REQS];
  logic              def_we;
  logic [QWID-1:0]   def_wdata;

  logic [LWID-1:0]   lens_a  [NUM_REQS];
  logic [QWID-1:0]   quant_a [NUM_REQS];
  logic [LWID-1:0]   head_len;
  logic [QWID:0]     credit_sum;
  logic [QWID-1:0]   credit_sat;
  logic [CNTWID-1:0] ptr_inc;

  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      lens_a[i]  = req_lens[i*LWID +: LWID];
      quant_a[i] = input_quantums[i*QWID +: QWID];
    end
  end

  // A zero length field still occupies one beat on the link.
  assign head_len   = (lens_a[ptr] == '0) ? LWID'(1) : lens_a[ptr];
  assign credit_sum = {1'b0, def_cnt[ptr]} + {1'b0, quant_a[ptr]};
  assign credit_sat = credit_sum[QWID] ? '1 : credit_sum[QWID-1:0];
  assign ptr_inc    = (ptr == CNTWID'(NUM_REQS - 1)) ? '0 : ptr + 1'b1;
  assign cur_idx    = ptr;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    visit_nxt = visit;
    beat_nxt  = beat_cnt;
    len_nxt   = len_q;
    def_we    = 1'b0;
    def_wdata = def_cnt[ptr];
    gnt       = '0;
    sop       = 1'b0;
    eop       = 1'b0;

    case (state)
      SCAN: begin
        if (!reqs[ptr]) begin
          def_we    = 1'b1;
          def_wdata = '0;
          visit_nxt = 1'b0;
          ptr_nxt   = ptr_inc;
        end else if (!visit) begin
          def_we    = 1'b1;
          def_wdata = credit_sat;
          visit_nxt = 1'b1;
        end else if (def_cnt[ptr] >= QWID'(head_len)) begin
          len_nxt   = head_len;
          beat_nxt  = head_len;
          state_nxt = SEND;
        end else begin
          visit_nxt = 1'b0;
          ptr_nxt   = ptr_inc;
        end
      end

      SEND: begin
        gnt[ptr] = 1'b1;
        sop      = (beat_cnt == len_q);
        eop      = (beat_cnt == LWID'(1));
        if (!blk) begin
          beat_nxt = beat_cnt - 1'b1;
          // visit stays set so the same queue is re-checked next cycle
          if (eop) begin
            def_we    = 1'b1;
            def_wdata = def_cnt[ptr] - QWID'(len_q);
            state_nxt = SCAN;
          end
        end
      end

      default: state_nxt = SCAN;
    endcase

    xfer = (|gnt) & ~blk;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SCAN;
      ptr      <= '0;
      visit    <= 1'b0;
      beat_cnt <= '0;
      len_q    <= '0;
      for (int i = 0; i < NUM_REQS; i++) def_cnt[i] <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      visit    <= visit_nxt;
      beat_cnt <= beat_nxt;
      len_q    <= len_nxt;
      if (def_we) def_cnt[ptr] <= def_wdata;
    end
  end

endmodule

// File: tb/tb_dwrr_pkt_sched.sv
// Bench for dwrr_pkt_sched: directed scenarios plus randomized traffic checked
// cycle by cycle against a round/visit-level reference model.
module tb_dwrr_pkt_sched;
  localparam int N    = 4;
  localparam int QW   = 8;
  localparam int LW   = 4;
  localparam int CW   = 2;
  localparam int MAXC = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          blk;
  logic [N-1:0]  reqs;
  logic [N*LW-1:0] req_lens;
  logic [N*QW-1:0] input_quantums;
  logic [N-1:0]  gnt;
  logic          xfer, sop, eop;
  logic [CW-1:0] cur_idx;

  dwrr_pkt_sched #(.NUM_REQS(N), .QWID(QW), .LWID(LW), .CNTWID(CW)) dut (
    .clk(clk), .rst(rst), .blk(blk), .reqs(reqs), .req_lens(req_lens),
    .input_quantums(input_quantums), .gnt(gnt), .xfer(xfer), .sop(sop),
    .eop(eop), .cur_idx(cur_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [N-1:0] cfg_reqs;
  int cfg_len [N];
  int cfg_q   [N];
  int cfg_blk_mode;
  int blk_lo, blk_hi;

  logic [8:0] exp_tr [$];
  logic       exp_blk [$];

  logic [N-1:0]  obs_gnt  [MAXC];
  logic          obs_sop  [MAXC];
  logic          obs_eop  [MAXC];
  logic          obs_xfer [MAXC];
  logic [CW-1:0] obs_idx  [MAXC];
  logic [QW-1:0] obs_def  [MAXC][N];

  function automatic logic pick_blk(input int k);
    if (cfg_blk_mode == 1) return ($urandom_range(3) == 0);
    if (cfg_blk_mode == 2) return (k >= blk_lo && k <= blk_hi);
    return 1'b0;
  endfunction

  function automatic void push(input logic [N-1:0] g, input logic s, input logic e,
                               input int p, input logic b);
    exp_blk.push_back(b);
    exp_tr.push_back({g, s, e, (|g) & ~b, CW'(p)});
  endfunction

  // Whole-round model: visit each queue in turn, credit once, then send packets
  // while the deficit covers the head length; every decision costs one cycle.
  task automatic build_model(input int ncyc);
    int mdef [N];
    int len_eff, b;
    logic bb;
    logic [N-1:0] g;
    exp_tr.delete();
    exp_blk.delete();
    for (int i = 0; i < N; i++) mdef[i] = 0;
    while (exp_tr.size() < ncyc) begin
      for (int p = 0; p < N; p++) begin
        if (!cfg_reqs[p]) begin
          mdef[p] = 0;
          push('0, 1'b0, 1'b0, p, pick_blk(exp_tr.size()));
        end else begin
          len_eff = (cfg_len[p] == 0) ? 1 : cfg_len[p];
          mdef[p] = (mdef[p] + cfg_q[p] > 255) ? 255 : mdef[p] + cfg_q[p];
          push('0, 1'b0, 1'b0, p, pick_blk(exp_tr.size()));
          forever begin
            push('0, 1'b0, 1'b0, p, pick_blk(exp_tr.size()));
            if (mdef[p] < len_eff) break;
            g = '0;
            g[p] = 1'b1;
            b = len_eff;
            while (b > 0) begin
              bb = pick_blk(exp_tr.size());
              push(g, b == len_eff, b == 1, p, bb);
              if (!bb) b--;
            end
            mdef[p] -= len_eff;
          end
        end
      end
    end
  endtask

  task automatic apply_cfg();
    reqs = cfg_reqs;
    for (int i = 0; i < N; i++) begin
      req_lens[i*LW +: LW]       = LW'(cfg_len[i]);
      input_quantums[i*QW +: QW] = QW'(cfg_q[i]);
    end
  endtask

  task automatic run_trace(input int ncyc, input string name);
    logic [8:0] got;
    int nprint;
    nprint = 0;
    build_model(ncyc);
    rst = 1'b1;
    blk = 1'b0;
    apply_cfg();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      blk = exp_blk[k];
      #1;
      obs_gnt[k]  = gnt;
      obs_sop[k]  = sop;
      obs_eop[k]  = eop;
      obs_xfer[k] = xfer;
      obs_idx[k]  = cur_idx;
      for (int i = 0; i < N; i++) obs_def[k][i] = dut.def_cnt[i];
      got = {gnt, sop, eop, xfer, cur_idx};
      n_checks++;
      if (got !== exp_tr[k]) begin
        if (nprint < 20) $display("FAIL %s trace cyc %0d {gnt,sop,eop,xfer,idx} got %b exp %b",
                                  name, k, got, exp_tr[k]);
        nprint++;
      end else n_pass++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    blk = 1'b0;
    reqs = '1;
    req_lens = N*LW'($urandom);
    input_quantums = N*QW'($urandom);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({gnt, xfer, sop, eop, cur_idx} !== '0) begin
      $display("FAIL reset outputs got %b exp 0", {gnt, xfer, sop, eop, cur_idx});
    end else n_pass++;
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (dut.def_cnt[i] !== '0) $display("FAIL reset def_cnt[%0d] got %0d exp 0", i, dut.def_cnt[i]);
      else n_pass++;
    end
  endtask

  task automatic test_single_queue();
    logic eg, es, ee;
    cfg_reqs = 4'b0001;
    cfg_len  = '{2, 1, 1, 1};
    cfg_q    = '{4, 0, 0, 0};
    cfg_blk_mode = 0;
    run_trace(16, "single");
    for (int k = 0; k < 16; k++) begin
      eg = (k == 2 || k == 3 || k == 5 || k == 6 || k == 13 || k == 14);
      es = (k == 2 || k == 5 || k == 13);
      ee = (k == 3 || k == 6 || k == 14);
      n_checks++;
      if ({obs_gnt[k][0], obs_sop[k], obs_eop[k]} !== {eg, es, ee})
        $display("FAIL single cyc %0d {gnt0,sop,eop} got %b exp %b", k,
                 {obs_gnt[k][0], obs_sop[k], obs_eop[k]}, {eg, es, ee});
      else n_pass++;
    end
  endtask

  task automatic test_deficit_carry();
    cfg_reqs = 4'b0010;
    cfg_len  = '{1, 4, 1, 1};
    cfg_q    = '{0, 3, 0, 0};
    cfg_blk_mode = 0;
    run_trace(20, "carry");
    n_checks++;
    if (obs_def[2][1] !== 8'd3) $display("FAIL carry first credit got %0d exp 3", obs_def[2][1]);
    else n_pass++;
    n_checks++;
    if (obs_def[7][1] !== 8'd6) $display("FAIL carry second credit got %0d exp 6", obs_def[7][1]);
    else n_pass++;
    n_checks++;
    if ({obs_gnt[8], obs_sop[8]} !== 5'b0010_1) $display("FAIL carry first sop got %b exp 00101", {obs_gnt[8], obs_sop[8]});
    else n_pass++;
    n_checks++;
    if ({obs_def[13][1], obs_idx[13]} !== {8'd2, 2'd2})
      $display("FAIL carry after send def/idx got %0d/%0d exp 2/2", obs_def[13][1], obs_idx[13]);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int nx;
    cfg_reqs = 4'b0001;
    cfg_len  = '{5, 1, 1, 1};
    cfg_q    = '{5, 0, 0, 0};
    cfg_blk_mode = 2;
    blk_lo = 4;
    blk_hi = 6;
    run_trace(20, "backpressure");
    for (int k = 4; k <= 6; k++) begin
      n_checks++;
      if ({obs_gnt[k][0], obs_xfer[k]} !== 2'b10)
        $display("FAIL stall cyc %0d {gnt0,xfer} got %b exp 10", k, {obs_gnt[k][0], obs_xfer[k]});
      else n_pass++;
    end
    n_checks++;
    if ({obs_eop[9], obs_xfer[9], obs_eop[6]} !== 3'b110)
      $display("FAIL stall eop timing got %b exp 110", {obs_eop[9], obs_xfer[9], obs_eop[6]});
    else n_pass++;
    nx = 0;
    for (int k = 0; k <= 12; k++) if (obs_xfer[k]) nx++;
    n_checks++;
    if (nx != 5) $display("FAIL stall beat count got %0d exp 5", nx);
    else n_pass++;
  endtask

  task automatic test_saturation();
    int n1, n2;
    cfg_reqs = 4'b0001;
    cfg_len  = '{15, 1, 1, 1};
    cfg_q    = '{250, 0, 0, 0};
    cfg_blk_mode = 0;
    run_trace(540, "saturation");
    n1 = 0;
    n2 = 0;
    for (int k = 0; k <= 533; k++) begin
      if (obs_sop[k] && obs_xfer[k]) begin
        n2++;
        if (k <= 256) n1++;
      end
    end
    n_checks++;
    if (n1 != 16) $display("FAIL sat first visit packets got %0d exp 16", n1);
    else n_pass++;
    n_checks++;
    if (n2 != 33) $display("FAIL sat total packets got %0d exp 33", n2);
    else n_pass++;
    n_checks++;
    if (obs_def[257][0] !== 8'd10) $display("FAIL sat leftover got %0d exp 10", obs_def[257][0]);
    else n_pass++;
    n_checks++;
    if (obs_def[262][0] !== 8'd255) $display("FAIL sat clamp got %0d exp 255", obs_def[262][0]);
    else n_pass++;
    n_checks++;
    if (obs_def[535][0] !== 8'd0) $display("FAIL sat drained got %0d exp 0", obs_def[535][0]);
    else n_pass++;
  endtask

  task automatic test_fairness();
    int seq [4];
    int nev, g3;
    seq = '{0, 0, 1, 2};
    cfg_reqs = 4'b1111;
    cfg_len  = '{4, 4, 4, 4};
    cfg_q    = '{8, 4, 4, 0};
    cfg_blk_mode = 1;
    run_trace(200, "fairness");
    nev = 0;
    g3 = 0;
    for (int k = 0; k < 200; k++) begin
      if (obs_gnt[k][3]) g3++;
      if (obs_sop[k] && obs_xfer[k]) begin
        n_checks++;
        if (int'(obs_idx[k]) != seq[nev % 4])
          $display("FAIL fairness packet %0d queue got %0d exp %0d", nev, obs_idx[k], seq[nev % 4]);
        else n_pass++;
        nev++;
      end
    end
    n_checks++;
    if (nev < 8) $display("FAIL fairness packet count got %0d exp >= 8", nev);
    else n_pass++;
    n_checks++;
    if (g3 != 0) $display("FAIL fairness queue3 grant cycles got %0d exp 0", g3);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic eop_seen;
    cfg_reqs = 4'b0001;
    cfg_len  = '{8, 1, 1, 1};
    cfg_q    = '{8, 0, 0, 0};
    rst = 1'b1;
    blk = 1'b0;
    apply_cfg();
    @(posedge clk);
    #1;
    rst = 1'b0;
    eop_seen = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      #1;
      eop_seen |= eop;
      if (k == 4) begin
        n_checks++;
        if ({gnt, sop, eop} !== 6'b0001_00) $display("FAIL midrst beat3 {gnt,sop,eop} got %b exp 000100", {gnt, sop, eop});
        else n_pass++;
        rst = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    #1;
    eop_seen |= eop;
    n_checks++;
    if ({gnt, cur_idx, eop_seen} !== '0)
      $display("FAIL midrst after reset {gnt,idx,eop_seen} got %b exp 0", {gnt, cur_idx, eop_seen});
    else n_pass++;
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (dut.def_cnt[i] !== '0) $display("FAIL midrst def_cnt[%0d] got %0d exp 0", i, dut.def_cnt[i]);
      else n_pass++;
    end
    rst = 1'b0;
    @(posedge clk);
    #2;
    n_checks++;
    if ({dut.def_cnt[0], cur_idx, gnt} !== {8'd8, 2'd0, 4'd0})
      $display("FAIL midrst recredit {def0,idx,gnt} got %0d/%0d/%b exp 8/0/0000", dut.def_cnt[0], cur_idx, gnt);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      cfg_reqs = N'($urandom);
      if (cfg_reqs == '0) cfg_reqs = 4'b0101;
      for (int i = 0; i < N; i++) begin
        cfg_len[i] = $urandom_range(15);
        case ($urandom_range(5))
          0: cfg_q[i] = 0;
          1: cfg_q[i] = $urandom_range(255, 240);
          default: cfg_q[i] = $urandom_range(40, 1);
        endcase
      end
      cfg_blk_mode = 1;
      run_trace(300, "random");
    end
  endtask

  initial begin
    rst = 1'b1;
    blk = 1'b0;
    reqs = '0;
    req_lens = '0;
    input_quantums = '0;
    test_reset();
    test_single_queue();
    test_deficit_carry();
    test_backpressure();
    test_saturation();
    test_fairness();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
